fifo_ctrl_fsm_p: RTL and testbench
==================================

FIFO_CTRL_FSM_P -- requirements
Module: fifo_ctrl_fsm_p

Interface
REQ-001 Parameter N_CH, default 5, number of FIFO channels supervised (1..16).
REQ-002 Parameter THR_W, default 5, bit width of each low/high threshold.
REQ-003 Parameter IDLE_DLY, default 4, consecutive all-empty cycles required to fall back from ACTIVE to IDLE (1..255).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 init  in  1  configuration request; high = load thresholds.
REQ-007 err_clr  in  1  clears sticky error state, one-cycle pulse.
REQ-008 thr_low_in  in  N_CH*THR_W  low thresholds; channel i in bits [i*THR_W +: THR_W].
REQ-009 thr_high_in  in  N_CH*THR_W  high thresholds, same packing.
REQ-010 empties  in  N_CH  per-channel FIFO empty flag, 1 = empty.
REQ-011 errors  in  N_CH  per-channel error flag, 1 = error this cycle.
REQ-012 thr_low_out  out  N_CH*THR_W  registered low thresholds.
REQ-013 thr_high_out  out  N_CH*THR_W  registered high thresholds.
REQ-014 state_out  out  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
REQ-015 idle_out, active_out, error_out  out  1 each  state indicators.
REQ-016 err_src  out  N_CH  sticky per-channel error record.
REQ-017 cfg_err  out  1  sticky: configuration rejected (some low > high).

Function
REQ-018 States RESET, INIT, IDLE, ACTIVE, ERROR; one-hot encoded; unreachable encodings go to RESET next cycle.
REQ-019 idle_out = (state==IDLE), active_out = (state==ACTIVE), error_out = (state==ERROR); decoded from state register only, no input-to-output combinational path.
REQ-020 RESET: thresholds, err_src, cfg_err, idle counter cleared; next state INIT unconditionally.
REQ-021 INIT: every cycle thr_*_out <= thr_*_in; while init=1 stay INIT.
REQ-022 INIT with init=0: compare captured values per channel, unsigned; any thr_low_out[i] > thr_high_out[i] -> ERROR and cfg_err<=1; else -> IDLE. low == high is legal.
REQ-023 Thresholds change only in INIT/RESET; held in IDLE, ACTIVE, ERROR.
REQ-024 IDLE: init=1 -> INIT (highest priority); else any errors bit -> ERROR, err_src |= errors; else any empties bit 0 -> ACTIVE; else stay.
REQ-025 ACTIVE: init=1 -> INIT; else any errors bit -> ERROR, err_src |= errors; else all empties=1 for IDLE_DLY consecutive cycles -> IDLE; else stay.
REQ-026 Idle counter counts all-empty cycles in ACTIVE, saturates at IDLE_DLY, clears on any non-empty cycle and on leaving ACTIVE; transition occurs on the edge where count reaches IDLE_DLY.
REQ-027 ERROR: err_src keeps accumulating errors each cycle; init=1 -> INIT clearing err_src and cfg_err; else err_clr=1 -> IDLE clearing err_src (cfg_err remains; cfg_err cleared only by INIT or reset); else stay.
REQ-028 err_clr ignored outside ERROR.
REQ-029 err_clr with cfg_err=1 -> INIT instead of IDLE (rejected config never run).
REQ-030 Simultaneous errors and err_clr in ERROR: clear wins, new errors in that cycle discarded.

Reset
REQ-031 reset=0 sampled on a rising edge forces state RESET, all outputs 0 except state_out=00001, regardless of current state or other inputs; mid-operation reset discards thresholds and errors.
REQ-032 Release: first edge with reset=1 moves RESET -> INIT; thresholds load from that cycle.

Verification
REQ-033 Reset then init=1 3 cycles with all thr_low=2, thr_high=9, init=0 -> IDLE, thr outputs hold 2/9, idle_out=1.
REQ-034 Config with ch3 low=10, high=4, init=0 -> ERROR, cfg_err=1; err_clr -> INIT, cfg_err still 1 until next INIT completes (cleared on entry).
REQ-035 IDLE, empties=11110 -> ACTIVE next cycle; empties=11111 held 4 cycles -> IDLE on 4th edge; a non-empty cycle at count 3 restarts count.
REQ-036 ACTIVE, errors=00100 one cycle then 00001 during ERROR -> err_src=00101, error_out=1; err_clr -> IDLE, err_src=00000.
REQ-037 Reset asserted while ACTIVE with err_src nonzero -> next edge state_out=00001, all thresholds and err_src 0.
REQ-038 N_CH=8, THR_W=7, IDLE_DLY=1 build: repeat REQ-033/035 with channel 7 in upper packed bits.

Source files
------------

// File: rtl/fifo_ctrl_fsm_p.sv
// Supervisor FSM for a bank of FIFO channels: captures per-channel thresholds,
// tracks activity and latches sticky per-channel and configuration errors.
module fifo_ctrl_fsm_p #(
  parameter int N_CH     = 5,
  parameter int THR_W    = 5,
  parameter int IDLE_DLY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    err_clr,
  input  logic [N_CH*THR_W-1:0]   thr_low_in,
  input  logic [N_CH*THR_W-1:0]   thr_high_in,
  input  logic [N_CH-1:0]         empties,
  input  logic [N_CH-1:0]         errors,
  output logic [N_CH*THR_W-1:0]   thr_low_out,
  output logic [N_CH*THR_W-1:0]   thr_high_out,
  output logic [4:0]              state_out,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [N_CH-1:0]         err_src,
  output logic                    cfg_err
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W:0] DLY_C = (CNT_W+1)'(IDLE_DLY);

  state_t                  state_r;
  logic [N_CH*THR_W-1:0]   thr_low_r;
  logic [N_CH*THR_W-1:0]   thr_high_r;
  logic [N_CH-1:0]         err_src_r;
  logic                    cfg_err_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W:0]          cnt_inc_s;

  // True when any channel's low threshold exceeds its high threshold (unsigned).
  function automatic logic cfg_bad_f(input logic [N_CH*THR_W-1:0] lo,
                                     input logic [N_CH*THR_W-1:0] hi);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (lo[i*THR_W +: THR_W] > hi[i*THR_W +: THR_W]) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Supervisor state machine with all state-dependent registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_RESET;
      thr_low_r  <= '0;
      thr_high_r <= '0;
      err_src_r  <= '0;
      cfg_err_r  <= 1'b0;
      cnt_r      <= '0;
    end else begin
      case (state_r)
        ST_RESET: begin
          thr_low_r  <= '0;
          thr_high_r <= '0;
          err_src_r  <= '0;
          cfg_err_r  <= 1'b0;
          cnt_r      <= '0;
          state_r    <= ST_INIT;
        end
        ST_INIT: begin
          thr_low_r  <= thr_low_in;
          thr_high_r <= thr_high_in;
          cnt_r      <= '0;
          if (init) begin
            state_r <= ST_INIT;
          end else if (cfg_bad_f(thr_low_r, thr_high_r)) begin
            state_r   <= ST_ERROR;
            cfg_err_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            cfg_err_r <= 1'b0;
          end
        end
        ST_IDLE: begin
          cnt_r <= '0;
          if (init) begin
            state_r <= ST_INIT;
          end else if (|errors) begin
            state_r   <= ST_ERROR;
            err_src_r <= err_src_r | errors;
          end else if (!(&empties)) begin
            state_r <= ST_ACTIVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (init) begin
            state_r <= ST_INIT;
            cnt_r   <= '0;
          end else if (|errors) begin
            state_r   <= ST_ERROR;
            err_src_r <= err_src_r | errors;
            cnt_r     <= '0;
          end else if (&empties) begin
            // Leave on the edge where the all-empty run reaches IDLE_DLY.
            if (cnt_inc_s >= DLY_C) begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_ACTIVE;
              cnt_r   <= cnt_inc_s[CNT_W-1:0];
            end
          end else begin
            state_r <= ST_ACTIVE;
            cnt_r   <= '0;
          end
        end
        ST_ERROR: begin
          cnt_r <= '0;
          if (init) begin
            state_r   <= ST_INIT;
            err_src_r <= '0;
            cfg_err_r <= 1'b0;
          end else if (err_clr) begin
            // A rejected configuration must be reloaded before running.
            state_r   <= cfg_err_r ? ST_INIT : ST_IDLE;
            err_src_r <= '0;
          end else begin
            state_r   <= ST_ERROR;
            err_src_r <= err_src_r | errors;
          end
        end
        default: begin
          state_r <= ST_RESET;
        end
      endcase
    end
  end

  assign state_out    = state_r;
  assign idle_out     = (state_r == ST_IDLE);
  assign active_out   = (state_r == ST_ACTIVE);
  assign error_out    = (state_r == ST_ERROR);
  assign thr_low_out  = thr_low_r;
  assign thr_high_out = thr_high_r;
  assign err_src      = err_src_r;
  assign cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_fifo_ctrl_fsm_p.sv
// Directed bench for fifo_ctrl_fsm_p: default build driven from a vector
// table, plus an 8-channel / IDLE_DLY=1 build driven by a hand sequence.
module tb_fifo_ctrl_fsm_p;

  localparam logic [4:0] S_RST = 5'b00001;
  localparam logic [4:0] S_INI = 5'b00010;
  localparam logic [4:0] S_IDL = 5'b00100;
  localparam logic [4:0] S_ACT = 5'b01000;
  localparam logic [4:0] S_ERR = 5'b10000;

  localparam logic [24:0] Z25 = 25'd0;
  localparam logic [24:0] L2  = {5{5'd2}};
  localparam logic [24:0] H9  = {5{5'd9}};
  localparam logic [24:0] LB  = {5'd2, 5'd10, 5'd2, 5'd2, 5'd2};
  localparam logic [24:0] HB  = {5'd9, 5'd4, 5'd9, 5'd9, 5'd9};

  localparam logic [55:0] L8  = {7'd100, {7{7'd2}}};
  localparam logic [55:0] H8  = {7'd120, {7{7'd9}}};
  localparam logic [55:0] L8B = {7'd120, {7{7'd2}}};
  localparam logic [55:0] H8B = {7'd100, {7{7'd9}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, init, err_clr;
  logic [24:0] thr_low_in, thr_high_in, thr_low_out, thr_high_out;
  logic [4:0]  empties, errors, state_out, err_src;
  logic        idle_out, active_out, error_out, cfg_err;

  logic        r8, i8, c8;
  logic [55:0] lo8, hi8, lo8o, hi8o;
  logic [7:0]  e8, er8, src8;
  logic [4:0]  st8;
  logic        idle8, act8, err8o, cfg8;

  fifo_ctrl_fsm_p dut (
    .clk(clk), .reset(reset), .init(init), .err_clr(err_clr),
    .thr_low_in(thr_low_in), .thr_high_in(thr_high_in),
    .empties(empties), .errors(errors),
    .thr_low_out(thr_low_out), .thr_high_out(thr_high_out),
    .state_out(state_out), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .err_src(err_src), .cfg_err(cfg_err)
  );

  fifo_ctrl_fsm_p #(.N_CH(8), .THR_W(7), .IDLE_DLY(1)) dut8 (
    .clk(clk), .reset(r8), .init(i8), .err_clr(c8),
    .thr_low_in(lo8), .thr_high_in(hi8),
    .empties(e8), .errors(er8),
    .thr_low_out(lo8o), .thr_high_out(hi8o),
    .state_out(st8), .idle_out(idle8), .active_out(act8),
    .error_out(err8o), .err_src(src8), .cfg_err(cfg8)
  );

  typedef struct {
    logic        rst, ini, clr;
    logic [4:0]  emp, err;
    logic [24:0] lo, hi;
    logic [4:0]  st, src;
    logic        cfg;
    logic [24:0] elo, ehi;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errs   = 0;

  function automatic vec_t mk(input logic rst, ini, clr, input logic [4:0] emp, err,
                              input logic [24:0] lo, hi, input logic [4:0] st, src,
                              input logic cfg, input logic [24:0] elo, ehi);
    vec_t v;
    v.rst = rst; v.ini = ini; v.clr = clr; v.emp = emp; v.err = err;
    v.lo = lo; v.hi = hi; v.st = st; v.src = src; v.cfg = cfg;
    v.elo = elo; v.ehi = ehi;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string nm, input logic [4:0] st, input logic cfg);
    chk({nm, " state"}, 64'(st8), 64'(st));
    chk({nm, " ind"}, 64'({err8o, act8, idle8}), 64'(st[4:2]));
    chk({nm, " cfg"}, 64'(cfg8), 64'(cfg));
  endtask

  initial begin
    // rst ini clr emp err lo hi | st src cfg elo ehi
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,L2,H9, S_INI,5'h00,0,Z25,Z25));
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,L2,H9, S_INI,5'h00,0,L2,H9));
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,L2,H9, S_INI,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_IDL,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,Z25,Z25, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_IDL,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h04,L2,H9, S_ERR,5'h04,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h01,L2,H9, S_ERR,5'h05,0,L2,H9));
    tbl.push_back(mk(1,0,1,5'h1E,5'h02,L2,H9, S_IDL,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,1,5'h1F,5'h00,L2,H9, S_IDL,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h00,L2,H9, S_ACT,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1E,5'h08,L2,H9, S_ERR,5'h08,0,L2,H9));
    tbl.push_back(mk(0,1,0,5'h1E,5'h08,LB,HB, S_RST,5'h00,0,Z25,Z25));
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,LB,HB, S_INI,5'h00,0,Z25,Z25));
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,LB,HB, S_INI,5'h00,0,LB,HB));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,LB,HB, S_ERR,5'h00,1,LB,HB));
    tbl.push_back(mk(1,0,0,5'h1F,5'h02,LB,HB, S_ERR,5'h02,1,LB,HB));
    tbl.push_back(mk(1,0,1,5'h1F,5'h00,LB,HB, S_INI,5'h00,1,LB,HB));
    tbl.push_back(mk(1,1,0,5'h1F,5'h00,L2,H9, S_INI,5'h00,1,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_IDL,5'h00,0,L2,H9));
    tbl.push_back(mk(1,1,0,5'h1F,5'h1F,L2,H9, S_INI,5'h00,0,L2,H9));
    tbl.push_back(mk(1,0,0,5'h1F,5'h00,L2,H9, S_IDL,5'h00,0,L2,H9));

    // Default build: reset state with busy inputs.
    reset = 1'b0; init = 1'b1; err_clr = 1'b1; empties = 5'h00; errors = 5'h1F;
    thr_low_in = L2; thr_high_in = H9;
    r8 = 1'b0; i8 = 1'b0; c8 = 1'b0; e8 = 8'hFF; er8 = 8'h00; lo8 = L8; hi8 = H8;
    tick();
    tick();
    chk("rst state", 64'(state_out), 64'(S_RST));
    chk("rst ind", 64'({error_out, active_out, idle_out}), 64'd0);
    chk("rst lo", 64'(thr_low_out), 64'd0);
    chk("rst hi", 64'(thr_high_out), 64'd0);
    chk("rst src", 64'(err_src), 64'd0);
    chk("rst cfg", 64'(cfg_err), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; init = tbl[i].ini; err_clr = tbl[i].clr;
      empties = tbl[i].emp; errors = tbl[i].err;
      thr_low_in = tbl[i].lo; thr_high_in = tbl[i].hi;
      tick();
      chk($sformatf("r%0d state", i), 64'(state_out), 64'(tbl[i].st));
      chk($sformatf("r%0d ind", i), 64'({error_out, active_out, idle_out}), 64'(tbl[i].st[4:2]));
      chk($sformatf("r%0d src", i), 64'(err_src), 64'(tbl[i].src));
      chk($sformatf("r%0d cfg", i), 64'(cfg_err), 64'(tbl[i].cfg));
      chk($sformatf("r%0d lo", i), 64'(thr_low_out), 64'(tbl[i].elo));
      chk($sformatf("r%0d hi", i), 64'(thr_high_out), 64'(tbl[i].ehi));
    end

    // Wide build: channel 7 in upper packed bits, one-cycle idle fallback.
    tick();
    chk8("w rst", S_RST, 1'b0);
    chk("w rst lo", 64'(lo8o), 64'd0);
    r8 = 1'b1; i8 = 1'b1;
    tick();
    chk8("w ini0", S_INI, 1'b0);
    tick();
    chk8("w ini1", S_INI, 1'b0);
    chk("w lo", 64'(lo8o), 64'(L8));
    chk("w hi", 64'(hi8o), 64'(H8));
    chk("w ch7 lo", 64'(lo8o[55:49]), 64'd100);
    i8 = 1'b0;
    tick();
    chk8("w idle", S_IDL, 1'b0);
    e8 = 8'h7F;
    tick();
    chk8("w act", S_ACT, 1'b0);
    e8 = 8'hFF;
    tick();
    chk8("w back idle", S_IDL, 1'b0);
    e8 = 8'h7F;
    tick();
    chk8("w act2", S_ACT, 1'b0);
    e8 = 8'hFF; lo8 = 56'd0;
    tick();
    chk8("w idle2", S_IDL, 1'b0);
    chk("w lo held", 64'(lo8o), 64'(L8));
    i8 = 1'b1; lo8 = L8B; hi8 = H8B;
    tick();
    tick();
    chk8("w bad ini", S_INI, 1'b0);
    i8 = 1'b0;
    tick();
    chk8("w bad err", S_ERR, 1'b1);
    i8 = 1'b1;
    tick();
    chk8("w err init", S_INI, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
